wb_port_arbiter: RTL
====================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning pending-write FIFO entries (power of two, >=4).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port mem_valid  input  1  memory-path write request this cycle.
REQ-005 SHALL have port mem_dir  input  4  memory-path destination register.
REQ-006 SHALL have port mem_data  input  32  memory-path write data.
REQ-007 SHALL have port alu_valid  input  1  ALU-path write request this cycle.
REQ-008 SHALL have port alu_dir  input  4  ALU-path destination register.
REQ-009 SHALL have port alu_data  input  32  ALU-path write data.
REQ-010 SHALL have port rd_query  input  4  register address checked against pending writes.
REQ-011 SHALL have port reg_wr_out  output  1  register-file write enable (registered).
REQ-012 SHALL have port dir_wb_out  output  4  register-file write address (registered).
REQ-013 SHALL have port data_out  output  32  register-file write data (registered).
REQ-014 SHALL have port stall  output  1  upstream must hold new requests.
REQ-015 SHALL have port pend_hit  output  1  some valid FIFO entry targets rd_query.
REQ-016 SHALL have port pend_cnt  output  log2(DEPTH)+1  current FIFO occupancy.
REQ-017 SHALL have port overflow  output  1  sticky error: a request was dropped.

Function
REQ-018 SHALL grant at most one register-file write per cycle.
REQ-019 SHALL order same-cycle arrivals as MEM first, then ALU.
REQ-020 SHALL preserve global arrival order: a FIFO head, if present, always wins over new arrivals.
REQ-021 SHALL, when FIFO is empty, write the first arrival directly (latency 1 cycle, input to reg_wr_out) and enqueue the second, if any.
REQ-022 SHALL, when FIFO is non-empty, pop the head to the outputs and enqueue all valid arrivals in order.
REQ-023 SHALL drive reg_wr_out=0 in any cycle with no grant; dir_wb_out/data_out hold their previous values.
REQ-024 SHALL compute space = DEPTH - pend_cnt + pop; arrivals beyond space are dropped, ALU first, and overflow set to 1 until reset.
REQ-025 SHALL assert stall combinationally when pend_cnt >= DEPTH-1.
REQ-026 SHALL update pend_cnt as pend_cnt + pushes - pops per cycle, with simultaneous push and pop at full allowed.
REQ-027 SHALL wrap read and write pointers modulo DEPTH.
REQ-028 SHALL compute pend_hit combinationally over valid entries only; entry being popped this cycle still counts.
REQ-029 SHALL not merge or reorder entries with equal destination; both writes occur in order.

Reset
REQ-030 SHALL, on rst=1, immediately clear reg_wr_out, dir_wb_out, data_out, pointers, pend_cnt and overflow to 0, so stall=0 and pend_hit=0.
REQ-031 SHALL discard all pending entries on reset mid-operation; no write issues on the first edge after rst deasserts unless a request is present.

Verification
REQ-032 SHALL cover: alu_valid=1, alu_dir=3, alu_data=0x11, FIFO empty -> next cycle reg_wr_out=1, dir_wb_out=3, data_out=0x11, pend_cnt=0.
REQ-033 SHALL cover: same cycle mem(5,0xAA) and alu(6,0xBB) -> cycle+1 writes 5/0xAA with pend_cnt=1, cycle+2 writes 6/0xBB with pend_cnt=0.
REQ-034 SHALL cover: two dual requests on consecutive cycles, DEPTH=4 -> pend_cnt goes 1, 2; stall=0, then 1 after a third dual; writes emerge in order MEM,ALU,MEM,ALU,...
REQ-035 SHALL cover: pend_cnt=4, requests ignore stall with dual request -> one pop, MEM enqueued, ALU dropped, overflow=1 and stays 1.
REQ-036 SHALL cover: entry for r9 buffered, rd_query=9 -> pend_hit=1; after it is written, pend_hit=0.
REQ-037 SHALL cover: rst pulsed asynchronously with pend_cnt=3 -> all outputs 0 without a clock edge; no buffered write ever appears.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: merges the memory-path and ALU-path register write-back
// requests into a single register-file write port. When the two paths collide,
// or when older writes are still waiting, requests are parked in a small
// in-order FIFO. Each pending entry's destination can be queried (pend_hit) so
// that issue logic can detect hazards against not-yet-written registers.
//
// Request/flow-control contract: a request is presented by raising *_valid
// with its *_dir/*_data for exactly the cycle it should be taken. There is no
// per-request acknowledge. Upstream is expected to hold off new requests while
// stall is high. stall rises at DEPTH-1 occupancy, so a dual request arriving
// in the same cycle as stall still fits. Requests that arrive while there is no
// room are dropped, ALU first, and overflow latches until reset.
module wb_port_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_valid,
  input  logic [3:0]                 mem_dir,
  input  logic [31:0]                mem_data,
  input  logic                       alu_valid,
  input  logic [3:0]                 alu_dir,
  input  logic [31:0]                alu_data,
  input  logic [3:0]                 rd_query,
  output logic                       reg_wr_out,
  output logic [3:0]                 dir_wb_out,
  output logic [31:0]                data_out,
  output logic                       stall,
  output logic                       pend_hit,
  output logic [$clog2(DEPTH):0]     pend_cnt,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // FIFO storage. It holds data only; validity comes from rd_ptr/cnt.
  logic [3:0]    ent_dir  [DEPTH];
  logic [31:0]   ent_data [DEPTH];

  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          ovf_q;

  // Registered write-port outputs.
  logic          wr_q;
  logic [3:0]    dir_q;
  logic [31:0]   data_q;

  // Per-cycle decisions.
  logic          fifo_empty;
  logic          pop;
  logic          grant;
  logic [3:0]    grant_dir;
  logic [31:0]   grant_data;
  logic [1:0]    n_cand;
  logic [3:0]    cand0_dir;
  logic [31:0]   cand0_data;
  logic [3:0]    cand1_dir;
  logic [31:0]   cand1_data;
  logic [CW:0]   space;
  logic [1:0]    n_push;
  logic          drop;
  logic [AW-1:0] wr_ptr_p1;
  logic          pend_hit_c;

  assign fifo_empty = (cnt_q == '0);
  assign pop        = !fifo_empty;
  assign wr_ptr_p1  = wr_ptr_q + AW'(1);

  // Choose the write-port grant and the ordered list of arrivals to enqueue.
  always_comb begin
    grant      = 1'b0;
    grant_dir  = ent_dir[rd_ptr_q];
    grant_data = ent_data[rd_ptr_q];
    n_cand     = 2'd0;
    cand0_dir  = mem_dir;
    cand0_data = mem_data;
    cand1_dir  = alu_dir;
    cand1_data = alu_data;
    if (!fifo_empty) begin
      // Older buffered writes always go first; every arrival queues behind.
      grant = 1'b1;
      if (mem_valid && alu_valid) begin
        n_cand = 2'd2;
      end else if (mem_valid) begin
        n_cand = 2'd1;
      end else if (alu_valid) begin
        n_cand     = 2'd1;
        cand0_dir  = alu_dir;
        cand0_data = alu_data;
      end
    end else begin
      // Nothing is waiting: the first arrival bypasses the FIFO.
      if (mem_valid) begin
        grant      = 1'b1;
        grant_dir  = mem_dir;
        grant_data = mem_data;
        if (alu_valid) begin
          n_cand     = 2'd1;
          cand0_dir  = alu_dir;
          cand0_data = alu_data;
        end
      end else if (alu_valid) begin
        grant      = 1'b1;
        grant_dir  = alu_dir;
        grant_data = alu_data;
      end
    end
  end

  // Room this cycle counts the slot freed by a simultaneous pop.
  always_comb begin
    space  = (CW+1)'(DEPTH) - {1'b0, cnt_q} + (CW+1)'(pop);
    n_push = n_cand;
    drop   = 1'b0;
    if ((CW+1)'(n_cand) > space) begin
      // Arrivals are ordered MEM then ALU, so truncating the list drops ALU.
      n_push = space[1:0];
      drop   = 1'b1;
    end
  end

  // Hazard lookup over the valid window [rd_ptr, rd_ptr + cnt). The head
  // still counts in the cycle it is popped.
  always_comb begin
    pend_hit_c = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [AW-1:0] offs;
      offs = AW'(i) - rd_ptr_q;
      if (({1'b0, offs} < cnt_q) && (ent_dir[i] == rd_query)) begin
        pend_hit_c = 1'b1;
      end
    end
  end

  // Write accepted arrivals into consecutive slots starting at wr_ptr.
  always_ff @(posedge clk) begin
    if (n_push != 2'd0) begin
      ent_dir[wr_ptr_q]  <= cand0_dir;
      ent_data[wr_ptr_q] <= cand0_data;
    end
    if (n_push == 2'd2) begin
      ent_dir[wr_ptr_p1]  <= cand1_dir;
      ent_data[wr_ptr_p1] <= cand1_data;
    end
  end

  // Pointers, occupancy and the sticky overflow flag. Pointers wrap
  // naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_q + AW'(pop);
      wr_ptr_q <= wr_ptr_q + AW'(n_push);
      cnt_q    <= cnt_q + CW'(n_push) - CW'(pop);
      if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Registered register-file write port. Address and data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q   <= 1'b0;
      dir_q  <= '0;
      data_q <= '0;
    end else begin
      wr_q <= grant;
      if (grant) begin
        dir_q  <= grant_dir;
        data_q <= grant_data;
      end
    end
  end

  assign reg_wr_out = wr_q;
  assign dir_wb_out = dir_q;
  assign data_out   = data_q;
  assign stall      = (cnt_q >= CW'(DEPTH - 1));
  assign pend_hit   = pend_hit_c;
  assign pend_cnt   = cnt_q;
  assign overflow   = ovf_q;

endmodule
